// File: rtl/mcpu_core_ifetch.sv
// Instruction fetch front end: fetch PC, one packet-aligned IL1 read per cycle, in-order packet queue to decode.
// Optional MCPU_IFETCH_BYPASS_EN lets an arriving packet drive decode directly when the queue is empty.
module mcpu_core_ifetch #(
  parameter int unsigned QUEUE_DEPTH = 4,
  parameter logic [27:0] RESET_PC    = 28'h0
) (
  input  logic         clkrst_core_clk,
  input  logic         clkrst_core_rst_n,
  input  logic         ft_redirect,
  input  logic [27:0]  ft_redirect_pc,
  output logic [27:0]  il1c_addr,
  output logic         il1c_re,
  input  logic [127:0] il1c_packet,
  input  logic         il1c_ready,
  input  logic         il1c_pf,
  output logic         ft2dec_valid,
  input  logic         ft2dec_ready,
  output logic [127:0] ft2dec_packet,
  output logic [27:0]  ft2dec_pc,
  output logic         ft2dec_pf
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(QUEUE_DEPTH);

  logic [27:0]        r_pc;
  logic               r_inflight;
  logic [27:0]        r_inflightPc;
  logic               r_squash;
  logic               r_halted;
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic [127:0]       r_queuePacket [QUEUE_DEPTH];
  logic [27:0]        r_queuePc     [QUEUE_DEPTH];
  logic               r_queuePf     [QUEUE_DEPTH];

  logic [CNT_W:0]     w_occupancy;
  logic               w_credit;
  logic               w_accept;
  logic               w_resp;
  logic               w_respLive;
  logic               w_queueEmpty;
  logic               w_bypass;
  logic               w_enq;
  logic               w_deq;
  logic [127:0]       w_respPacket;

  // Credit check counts the in-flight request but not a same-cycle dequeue, so the queue cannot overflow.
  assign w_occupancy  = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_credit     = (w_occupancy < DEPTH_C);
  assign il1c_re      = clkrst_core_rst_n & ~r_halted & ~ft_redirect & w_credit;
  assign il1c_addr    = r_pc;
  assign w_accept     = il1c_re & il1c_ready;

  assign w_resp       = r_inflight & il1c_ready;
  assign w_respLive   = w_resp & ~r_squash & ~ft_redirect;
  assign w_respPacket = il1c_pf ? 128'h0 : il1c_packet;
  assign w_queueEmpty = (r_count == '0);

`ifdef MCPU_IFETCH_BYPASS_EN
  assign w_bypass = w_respLive & w_queueEmpty;
`else
  assign w_bypass = 1'b0;
`endif

  assign ft2dec_valid = ~ft_redirect & (~w_queueEmpty | w_bypass);
  assign w_deq        = ft2dec_valid & ft2dec_ready & ~w_queueEmpty;
  assign w_enq        = w_respLive & ~(w_bypass & ft2dec_ready);

  always_comb begin
    ft2dec_packet = 128'h0;
    ft2dec_pc     = 28'h0;
    ft2dec_pf     = 1'b0;
    if (ft2dec_valid) begin
      if (w_bypass) begin
        ft2dec_packet = w_respPacket;
        ft2dec_pc     = r_inflightPc;
        ft2dec_pf     = il1c_pf;
      end else begin
        ft2dec_packet = r_queuePacket[r_head];
        ft2dec_pc     = r_queuePc[r_head];
        ft2dec_pf     = r_queuePf[r_head];
      end
    end
  end

  // A redirect empties the queue; squash survives only if the old request is still waiting on the cache.
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      r_pc         <= RESET_PC;
      r_inflight   <= 1'b0;
      r_inflightPc <= 28'h0;
      r_squash     <= 1'b0;
      r_halted     <= 1'b0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
    end else begin
      if (w_accept) begin
        r_inflightPc <= r_pc;
      end
      r_inflight <= w_accept | (r_inflight & ~il1c_ready);
      if (ft_redirect) begin
        r_pc     <= ft_redirect_pc;
        r_halted <= 1'b0;
        r_squash <= r_inflight & ~il1c_ready;
        r_head   <= '0;
        r_tail   <= '0;
        r_count  <= '0;
      end else begin
        if (w_accept) begin
          r_pc <= r_pc + 28'd1;
        end
        if (w_resp & r_squash) begin
          r_squash <= 1'b0;
        end
        if (w_respLive & il1c_pf) begin
          r_halted <= 1'b1;
        end
        if (w_enq) begin
          r_tail <= r_tail + PTR_W'(1);
        end
        if (w_deq) begin
          r_head <= r_head + PTR_W'(1);
        end
        r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_deq);
      end
    end
  end

  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        r_queuePacket[i] <= 128'h0;
        r_queuePc[i]     <= 28'h0;
        r_queuePf[i]     <= 1'b0;
      end
    end else if (w_enq) begin
      r_queuePacket[r_tail] <= w_respPacket;
      r_queuePc[r_tail]     <= r_inflightPc;
      r_queuePf[r_tail]     <= il1c_pf;
    end
  end

endmodule

// File: tb/tb_mcpu_core_ifetch.sv
// Directed-vector bench for mcpu_core_ifetch (default build, no bypass): table of per-cycle inputs and expected outputs,
// plus a hand-written reset-PC wrap sequence on a second instance with RESET_PC = 28'hFFFFFFF.
module tb_mcpu_core_ifetch;

  typedef struct {
    logic        rstN;
    logic        redir;
    logic [27:0] redirPc;
    logic        ready;
    logic        pf;
    logic        decReady;
    logic [27:0] tag;
    logic        expRe;
    logic [27:0] expAddr;
    logic        expValid;
    logic [27:0] expPc;
    logic        expPf;
  } vec_t;

  logic         clock;
  logic         rstN;
  logic         redirect;
  logic [27:0]  redirectPc;
  logic [127:0] cachePacket;
  logic         cacheReady;
  logic         cachePf;
  logic         decReady;

  logic [27:0]  il1cAddr;
  logic         il1cRe;
  logic         decValid;
  logic [127:0] decPacket;
  logic [27:0]  decPc;
  logic         decPf;

  logic [27:0]  wrapAddr;
  logic         wrapRe;
  logic         wrapValid;
  logic [127:0] wrapPacket;
  logic [27:0]  wrapPc;
  logic         wrapPf;

  int vectorsApplied = 0;
  int miscompares    = 0;
  vec_t vecs[$];

  mcpu_core_ifetch #(.QUEUE_DEPTH(4), .RESET_PC(28'h0)) dut (
    .clkrst_core_clk   (clock),
    .clkrst_core_rst_n (rstN),
    .ft_redirect       (redirect),
    .ft_redirect_pc    (redirectPc),
    .il1c_addr         (il1cAddr),
    .il1c_re           (il1cRe),
    .il1c_packet       (cachePacket),
    .il1c_ready        (cacheReady),
    .il1c_pf           (cachePf),
    .ft2dec_valid      (decValid),
    .ft2dec_ready      (decReady),
    .ft2dec_packet     (decPacket),
    .ft2dec_pc         (decPc),
    .ft2dec_pf         (decPf)
  );

  mcpu_core_ifetch #(.QUEUE_DEPTH(4), .RESET_PC(28'hFFFFFFF)) dutWrap (
    .clkrst_core_clk   (clock),
    .clkrst_core_rst_n (rstN),
    .ft_redirect       (redirect),
    .ft_redirect_pc    (redirectPc),
    .il1c_addr         (wrapAddr),
    .il1c_re           (wrapRe),
    .il1c_packet       (cachePacket),
    .il1c_ready        (cacheReady),
    .il1c_pf           (cachePf),
    .ft2dec_valid      (wrapValid),
    .ft2dec_ready      (decReady),
    .ft2dec_packet     (wrapPacket),
    .ft2dec_pc         (wrapPc),
    .ft2dec_pf         (wrapPf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Packet contents are tied to their address so the expected head packet follows from the expected head PC.
  function automatic logic [127:0] pktOf(input logic [27:0] a);
    return {4'h1, a, 4'h2, a, 4'h3, a, 4'h4, a};
  endfunction

  function automatic vec_t mk(input logic r, input logic rd, input logic [27:0] rdPc,
                              input logic rdy, input logic pf, input logic dr, input logic [27:0] tag,
                              input logic eRe, input logic [27:0] eAddr, input logic eValid,
                              input logic [27:0] ePc, input logic ePf);
    vec_t v;
    v.rstN = r;       v.redir = rd;     v.redirPc = rdPc;
    v.ready = rdy;    v.pf = pf;        v.decReady = dr;    v.tag = tag;
    v.expRe = eRe;    v.expAddr = eAddr; v.expValid = eValid;
    v.expPc = ePc;    v.expPf = ePf;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rstN        = v.rstN;
    redirect    = v.redir;
    redirectPc  = v.redirPc;
    cacheReady  = v.ready;
    cachePf     = v.pf;
    decReady    = v.decReady;
    cachePacket = pktOf(v.tag);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [127:0] expPkt;
    expPkt = (v.expValid && !v.expPf) ? pktOf(v.expPc) : 128'h0;
    vectorsApplied++;
    if (il1cRe !== v.expRe || il1cAddr !== v.expAddr || decValid !== v.expValid ||
        decPc !== v.expPc || decPf !== v.expPf || decPacket !== expPkt) begin
      miscompares++;
      $display("[TB] FAIL vec%0d: got re=%0b addr=%h valid=%0b pc=%h pf=%0b pkt=%h, want re=%0b addr=%h valid=%0b pc=%h pf=%0b pkt=%h",
               idx, il1cRe, il1cAddr, decValid, decPc, decPf, decPacket,
               v.expRe, v.expAddr, v.expValid, v.expPc, v.expPf, expPkt);
    end
  endtask

  task automatic checkWrap(input int step, input logic eRe, input logic [27:0] eAddr);
    vectorsApplied++;
    if (wrapRe !== eRe || wrapAddr !== eAddr) begin
      miscompares++;
      $display("[TB] FAIL wrap%0d: got re=%0b addr=%h, want re=%0b addr=%h", step, wrapRe, wrapAddr, eRe, eAddr);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // args: rstN redir redirPc ready pf decReady tag | expRe expAddr expValid expPc expPf
    // reset and streaming
    vecs.push_back(mk(0, 0, 28'h0,   1, 0, 1, 28'h0,   0, 28'h0,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h0,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h1,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h1,   1, 28'h2,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h2,   1, 28'h3,   1, 28'h1,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h3,   1, 28'h4,   1, 28'h2,   0));
    // reset mid-stream with a request in flight, then backpressure
    vecs.push_back(mk(0, 0, 28'h0,   1, 0, 1, 28'h4,   0, 28'h0,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h0,   1, 28'h0,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h0,   1, 28'h1,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h1,   1, 28'h2,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h2,   1, 28'h3,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h3,   0, 28'h4,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 0, 28'h0,   0, 28'h4,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   0, 28'h4,   1, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h4,   1, 28'h1,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h4,   1, 28'h5,   1, 28'h2,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h5,   1, 28'h6,   1, 28'h3,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h6,   1, 28'h7,   1, 28'h4,   0));
    // redirect to 10, stall the cache 5 cycles, redirect to 100 with the request still pending
    vecs.push_back(mk(1, 1, 28'h10,  1, 0, 1, 28'h7,   0, 28'h8,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h10,  0, 28'h0,   0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(1, 0, 28'h0, 0, 0, 1, 28'h0,   1, 28'h11,  0, 28'h0,   0));
    vecs.push_back(mk(1, 1, 28'h100, 0, 0, 1, 28'h0,   0, 28'h11,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   0, 0, 1, 28'h0,   1, 28'h100, 0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h10,  1, 28'h100, 0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h100, 1, 28'h101, 0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h101, 1, 28'h102, 1, 28'h100, 0));
    // page fault on address 7, then redirect to 20
    vecs.push_back(mk(1, 1, 28'h7,   1, 0, 1, 28'h102, 0, 28'h103, 0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h7,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 1, 1, 28'h7,   1, 28'h8,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   0, 0, 0, 28'h0,   0, 28'h9,   1, 28'h7,   1));
    vecs.push_back(mk(1, 0, 28'h0,   0, 0, 1, 28'h0,   0, 28'h9,   1, 28'h7,   1));
    vecs.push_back(mk(1, 0, 28'h0,   0, 0, 1, 28'h0,   0, 28'h9,   0, 28'h0,   0));
    vecs.push_back(mk(1, 1, 28'h20,  0, 0, 1, 28'h0,   0, 28'h9,   0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h8,   1, 28'h20,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h20,  1, 28'h21,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h21,  1, 28'h22,  1, 28'h20,  0));
    // redirect coinciding with a response and a ready decode
    vecs.push_back(mk(1, 1, 28'h55,  1, 0, 1, 28'h22,  0, 28'h23,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h0,   1, 28'h55,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h55,  1, 28'h56,  0, 28'h0,   0));
    vecs.push_back(mk(1, 0, 28'h0,   1, 0, 1, 28'h56,  1, 28'h57,  1, 28'h55,  0));

    applyStimulus(vecs[0]);
    @(negedge clock);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
      @(negedge clock);
    end

    // reset-PC wrap: FFFFFFF is fetched first, then the PC rolls over to 0
    rstN = 1'b0; redirect = 1'b0; cacheReady = 1'b1; cachePf = 1'b0; decReady = 1'b1;
    #1;
    checkWrap(0, 1'b0, 28'hFFFFFFF);
    @(negedge clock);
    rstN = 1'b1;
    #1;
    checkWrap(1, 1'b1, 28'hFFFFFFF);
    @(negedge clock);
    #1;
    checkWrap(2, 1'b1, 28'h0);
    @(negedge clock);
    #1;
    checkWrap(3, 1'b1, 28'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
